key_mode_controller: RTL and testbench

Front-end control stage for the digital clock: debounces the four push buttons, turns presses into single-cycle events, and runs the view/edit state machine. It feeds the mode, edit and edit-position signals to the display multiplexer. It also feeds the increment/decrement pulses to the second, minute and hour counters, which commit edits live.

---
 rtl/key_mode_controller_if.sv | 21 ++
 rtl/key_mode_controller.sv | 177 +++++++++++++++++
 tb/tb_key_mode_controller.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/key_mode_controller_if.sv
// Switch/button inputs and display/counter-facing outputs of the key/mode controller.
interface key_mode_controller_if;
  logic       Enable;
  logic       Hour12;
  logic [3:0] KEY;
  logic       EditMode;
  logic [1:0] Screen;
  logic [2:0] EditPos;
  logic       IncPulse;
  logic       DecPulse;

  modport master (
    output Enable, Hour12, KEY,
    input  EditMode, Screen, EditPos, IncPulse, DecPulse
  );

  modport slave (
    input  Enable, Hour12, KEY,
    output EditMode, Screen, EditPos, IncPulse, DecPulse
  );
endinterface

// File: rtl/key_mode_controller.sv
// Debounces the four keys, runs the VIEW/EDIT machine and makes inc/dec pulses with auto-repeat.
// A held key edge reaches the registered outputs DEBOUNCE_CYCLES+3 cycles later.
module key_mode_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_START    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input logic                  CLOCK_50,
  input logic                  Reset,
  key_mode_controller_if.slave io
);
  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_START > REPEAT_PERIOD) ? REPEAT_START : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RS_V     = RW'(REPEAT_START);
  localparam logic [RW-1:0] RP_V     = RW'(REPEAT_PERIOD);

  typedef enum logic {VIEW = 1'b0, EDIT = 1'b1} state_t;

  logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]    stable_q, stable_d, press_q, press_d;
  logic [DW-1:0] deb_cnt_q [4];
  logic [DW-1:0] deb_cnt_d [4];
  state_t        state_q, state_d;
  logic [1:0]    screen_q, screen_d;
  logic [2:0]    pos_q, pos_d;
  logic          inc_q, inc_d, dec_q, dec_d;
  logic [1:0]    arm_q, arm_d, first_q, first_d;
  logic [RW-1:0] rcnt_q [2];
  logic [RW-1:0] rcnt_d [2];
  logic [1:0]    fire;
  logic [2:0]    pos_norm, next_pos;
  logic          last_pos, both_held, in_edit, held, ev;

  // Keys are active-low; stable=1 means released, press_q flags the released->pressed update.
  always_comb begin
    sync1_d  = io.KEY;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    press_d  = '0;
    for (int i = 0; i < 4; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          stable_d[i] = sync2_q[i];
          press_d[i]  = ~sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    screen_d = screen_q;
    pos_d    = pos_q;
    arm_d    = arm_q;
    first_d  = first_q;
    rcnt_d   = rcnt_q;
    fire     = '0;
    held     = 1'b0;
    ev       = 1'b0;

    // A position that does not exist in the current hour format snaps to its neighbour.
    pos_norm = pos_q;
    if (io.Hour12 && pos_q == 3'd1)  pos_norm = 3'd0;
    if (!io.Hour12 && pos_q == 3'd7) pos_norm = 3'd5;

    if (io.Hour12) begin
      last_pos = (pos_norm == 3'd7);
      next_pos = (pos_norm == 3'd0) ? 3'd2 : (pos_norm == 3'd5) ? 3'd7 : pos_norm + 3'd1;
    end else begin
      last_pos = (pos_norm == 3'd5);
      next_pos = pos_norm + 3'd1;
    end

    case (state_q)
      VIEW: begin
        if (press_q[0]) begin
          screen_d = (screen_q == 2'd2) ? 2'd0 : screen_q + 2'd1;
        end else if (press_q[3] && screen_q == 2'd0) begin
          state_d = EDIT;
          pos_d   = 3'd0;
        end
      end
      EDIT: begin
        pos_d = pos_norm;
        if (press_q[0] || (press_q[3] && last_pos)) begin
          state_d = VIEW;
          pos_d   = 3'd0;
        end else if (press_q[3]) begin
          pos_d = next_pos;
        end
      end
      default: state_d = VIEW;
    endcase

    // Pulses only while staying in EDIT; a key must be pressed inside EDIT to arm its repeat.
    both_held = ~stable_q[1] & ~stable_q[2];
    in_edit   = (state_q == EDIT) && (state_d == EDIT);
    for (int k = 0; k < 2; k++) begin
      held = ~stable_q[k+1];
      ev   = press_q[k+1];
      if (!held || both_held || !in_edit) begin
        arm_d[k]   = 1'b0;
        first_d[k] = 1'b0;
        rcnt_d[k]  = '0;
      end else if (ev) begin
        fire[k]    = 1'b1;
        arm_d[k]   = 1'b1;
        first_d[k] = 1'b1;
        rcnt_d[k]  = RW'(1);
      end else if (arm_q[k]) begin
        if (rcnt_q[k] == (first_q[k] ? RS_V : RP_V)) begin
          fire[k]    = 1'b1;
          first_d[k] = 1'b0;
          rcnt_d[k]  = RW'(1);
        end else begin
          rcnt_d[k] = rcnt_q[k] + 1'b1;
        end
      end
    end
    inc_d = fire[0];
    dec_d = fire[1];

    if (!io.Enable) begin
      state_d  = VIEW;
      screen_d = 2'd0;
      pos_d    = 3'd0;
      inc_d    = 1'b0;
      dec_d    = 1'b0;
      arm_d    = '0;
      first_d  = '0;
      rcnt_d   = '{default: '0};
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      stable_q  <= '1;
      press_q   <= '0;
      deb_cnt_q <= '{default: '0};
      state_q   <= VIEW;
      screen_q  <= 2'd0;
      pos_q     <= 3'd0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      arm_q     <= '0;
      first_q   <= '0;
      rcnt_q    <= '{default: '0};
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      deb_cnt_q <= deb_cnt_d;
      state_q   <= state_d;
      screen_q  <= screen_d;
      pos_q     <= pos_d;
      inc_q     <= inc_d;
      dec_q     <= dec_d;
      arm_q     <= arm_d;
      first_q   <= first_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign io.EditMode = state_q;
  assign io.Screen   = screen_q;
  assign io.EditPos  = pos_q;
  assign io.IncPulse = inc_q;
  assign io.DecPulse = dec_q;
endmodule

// File: tb/tb_key_mode_controller.sv
// Bench for key_mode_controller: table of key presses plus hand-written repeat/reset/enable sequences.
module tb_key_mode_controller;
  logic CLOCK_50 = 1'b0;
  logic Reset;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic started = 1'b0;

  key_mode_controller_if io();

  key_mode_controller #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_START   (20),
    .REPEAT_PERIOD  (5)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .Reset   (Reset),
    .io      (io)
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic       edit;
    logic [1:0] screen;
    logic [2:0] pos;
    logic       inc;
    logic       dec;
    string      name;
  } exp_t;

  typedef struct {
    logic [3:0] keys;
    logic       h12;
    int         hold;
    logic       edit;
    logic [1:0] screen;
    logic [2:0] pos;
    string      name;
  } vec_t;

  exp_t sb[$];
  exp_t cur;
  vec_t vecs[$];

  // Expected display state, advanced by the stimulus.
  logic       m_edit   = 1'b0;
  logic [1:0] m_screen = 2'd0;
  logic [2:0] m_pos    = 3'd0;

  task automatic push_exp(input int due, input logic inc, input logic dec, input string name);
    exp_t e;
    e.due = due; e.edit = m_edit; e.screen = m_screen; e.pos = m_pos;
    e.inc = inc; e.dec = dec; e.name = name;
    sb.push_back(e);
  endtask

  task automatic add_vec(input logic [3:0] keys, input logic h12, input int hold,
                         input logic edit, input logic [1:0] scr, input logic [2:0] pos,
                         input string name);
    vec_t v;
    v.keys = keys; v.h12 = h12; v.hold = hold;
    v.edit = edit; v.screen = scr; v.pos = pos; v.name = name;
    vecs.push_back(v);
  endtask

  // Output must change exactly 7 cycles after the raw edge: unchanged at +6, new at +7.
  task automatic press(input logic [3:0] keys, input logic h12, input int hold,
                       input logic edit, input logic [1:0] scr, input logic [2:0] pos,
                       input string name);
    int b;
    @(posedge CLOCK_50); #1;
    io.Hour12 = h12;
    io.KEY    = ~keys;
    b = cyc;
    push_exp(b + 6, 1'b0, 1'b0, {name, "_pre"});
    m_edit = edit; m_screen = scr; m_pos = pos;
    push_exp(b + 7, 1'b0, 1'b0, name);
    repeat (hold) @(posedge CLOCK_50);
    #1 io.KEY = 4'hF;
    repeat (12) @(posedge CLOCK_50);
  endtask

  always @(negedge CLOCK_50) begin
    if (started) begin
      checks++;
      if (io.IncPulse === 1'b1 && io.DecPulse === 1'b1) begin
        errors++;
        $display("FAIL both_pulses @%0d: IncPulse=%0b DecPulse=%0b, never both 1", cyc, io.IncPulse, io.DecPulse);
      end
    end
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      cur = sb.pop_front();
      checks++;
      if (cur.due != cyc || io.EditMode !== cur.edit || io.Screen !== cur.screen ||
          io.EditPos !== cur.pos || io.IncPulse !== cur.inc || io.DecPulse !== cur.dec) begin
        errors++;
        $display("FAIL %s @%0d (due %0d): got edit=%0b screen=%0d pos=%0d inc=%0b dec=%0b, want edit=%0b screen=%0d pos=%0d inc=%0b dec=%0b",
                 cur.name, cyc, cur.due, io.EditMode, io.Screen, io.EditPos, io.IncPulse, io.DecPulse,
                 cur.edit, cur.screen, cur.pos, cur.inc, cur.dec);
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;

    add_vec(4'b0001, 1'b0, 10, 1'b0, 2'd1, 3'd0, "scr_1");
    add_vec(4'b0001, 1'b0, 10, 1'b0, 2'd2, 3'd0, "scr_2");
    add_vec(4'b0001, 1'b0, 10, 1'b0, 2'd0, 3'd0, "scr_0");
    add_vec(4'b0001, 1'b0,  3, 1'b0, 2'd0, 3'd0, "glitch");
    add_vec(4'b1000, 1'b0, 10, 1'b1, 2'd0, 3'd0, "e24_p0");
    add_vec(4'b1000, 1'b0, 10, 1'b1, 2'd0, 3'd1, "e24_p1");
    add_vec(4'b1000, 1'b0, 10, 1'b1, 2'd0, 3'd2, "e24_p2");
    add_vec(4'b1000, 1'b0, 10, 1'b1, 2'd0, 3'd3, "e24_p3");
    add_vec(4'b1000, 1'b0, 10, 1'b1, 2'd0, 3'd4, "e24_p4");
    add_vec(4'b1000, 1'b0, 10, 1'b1, 2'd0, 3'd5, "e24_p5");
    add_vec(4'b1000, 1'b0, 10, 1'b0, 2'd0, 3'd0, "e24_exit");
    add_vec(4'b1000, 1'b1, 10, 1'b1, 2'd0, 3'd0, "e12_p0");
    add_vec(4'b1000, 1'b1, 10, 1'b1, 2'd0, 3'd2, "e12_p2");
    add_vec(4'b1000, 1'b1, 10, 1'b1, 2'd0, 3'd3, "e12_p3");
    add_vec(4'b1000, 1'b1, 10, 1'b1, 2'd0, 3'd4, "e12_p4");
    add_vec(4'b1000, 1'b1, 10, 1'b1, 2'd0, 3'd5, "e12_p5");
    add_vec(4'b1000, 1'b1, 10, 1'b1, 2'd0, 3'd7, "e12_p7");
    add_vec(4'b1000, 1'b1, 10, 1'b0, 2'd0, 3'd0, "e12_exit");

    Reset = 1'b1;
    io.Enable = 1'b1;
    io.Hour12 = 1'b0;
    io.KEY = 4'hF;
    repeat (3) @(posedge CLOCK_50);
    #1 push_exp(cyc, 1'b0, 1'b0, "reset");
    Reset = 1'b0;
    started = 1'b1;
    repeat (10) @(posedge CLOCK_50);

    for (int i = 0; i < vecs.size(); i++)
      press(vecs[i].keys, vecs[i].h12, vecs[i].hold, vecs[i].edit, vecs[i].screen, vecs[i].pos, vecs[i].name);

    // Auto-repeat: pulses at +7, +27, +32; released before the +37 pulse.
    press(4'b1000, 1'b0, 10, 1'b1, 2'd0, 3'd0, "rep_enter");
    @(posedge CLOCK_50); #1;
    io.KEY = ~4'b0010;
    b = cyc;
    for (int t = 1; t <= 45; t++) push_exp(b + t, (t == 7 || t == 27 || t == 32), 1'b0, "inc_repeat");
    repeat (30) @(posedge CLOCK_50);
    #1 io.KEY = 4'hF;
    repeat (16) @(posedge CLOCK_50);

    @(posedge CLOCK_50); #1;
    io.KEY = ~4'b0110;
    b = cyc;
    for (int t = 1; t <= 50; t++) push_exp(b + t, 1'b0, 1'b0, "inc_dec_both");
    repeat (40) @(posedge CLOCK_50);
    #1 io.KEY = 4'hF;
    repeat (16) @(posedge CLOCK_50);

    // Hour12 flips while editing.
    press(4'b1000, 1'b0, 10, 1'b1, 2'd0, 3'd1, "h_p1");
    @(posedge CLOCK_50); #1;
    b = cyc;
    push_exp(b, 1'b0, 1'b0, "h12_before");
    io.Hour12 = 1'b1;
    m_pos = 3'd0;
    push_exp(b + 1, 1'b0, 1'b0, "h12_snap_0");
    press(4'b1000, 1'b1, 10, 1'b1, 2'd0, 3'd2, "h_p2");
    press(4'b1000, 1'b1, 10, 1'b1, 2'd0, 3'd3, "h_p3");
    press(4'b1000, 1'b1, 10, 1'b1, 2'd0, 3'd4, "h_p4");
    press(4'b1000, 1'b1, 10, 1'b1, 2'd0, 3'd5, "h_p5");
    press(4'b1000, 1'b1, 10, 1'b1, 2'd0, 3'd7, "h_p7");
    @(posedge CLOCK_50); #1;
    b = cyc;
    push_exp(b, 1'b0, 1'b0, "h24_before");
    io.Hour12 = 1'b0;
    m_pos = 3'd5;
    push_exp(b + 1, 1'b0, 1'b0, "h24_snap_5");
    press(4'b1000, 1'b0, 10, 1'b0, 2'd0, 3'd0, "h_exit");

    // KEY[0] beats KEY[3]; KEY[3] ignored off the time screen.
    press(4'b1000, 1'b0, 10, 1'b1, 2'd0, 3'd0, "m_p0");
    press(4'b1000, 1'b0, 10, 1'b1, 2'd0, 3'd1, "m_p1");
    press(4'b1001, 1'b0, 10, 1'b0, 2'd0, 3'd0, "mode_wins");
    press(4'b0001, 1'b0, 10, 1'b0, 2'd1, 3'd0, "scr1_again");
    press(4'b1000, 1'b0, 10, 1'b0, 2'd1, 3'd0, "k3_ignored");
    press(4'b0001, 1'b0, 10, 1'b0, 2'd2, 3'd0, "scr2_again");
    press(4'b0001, 1'b0, 10, 1'b0, 2'd0, 3'd0, "scr0_again");
    press(4'b1000, 1'b0, 10, 1'b1, 2'd0, 3'd0, "rst_enter");

    // Reset sampled at +30, between the +27 and +32 repeat pulses.
    @(posedge CLOCK_50); #1;
    io.KEY = ~4'b0010;
    b = cyc;
    for (int t = 1; t <= 29; t++) push_exp(b + t, (t == 7 || t == 27), 1'b0, "rst_repeat");
    m_edit = 1'b0; m_screen = 2'd0; m_pos = 3'd0;
    for (int t = 30; t <= 60; t++) push_exp(b + t, 1'b0, 1'b0, "rst_quiet");
    repeat (29) @(posedge CLOCK_50);
    #1 Reset = 1'b1;
    @(posedge CLOCK_50);
    #1 Reset = 1'b0;
    repeat (10) @(posedge CLOCK_50);
    #1 io.KEY = 4'hF;
    repeat (25) @(posedge CLOCK_50);

    // Enable low clears outputs; a key held across Enable rising makes no event.
    press(4'b0001, 1'b0, 10, 1'b0, 2'd1, 3'd0, "en_scr1");
    press(4'b0001, 1'b0, 10, 1'b0, 2'd2, 3'd0, "en_scr2");
    @(posedge CLOCK_50); #1;
    b = cyc;
    push_exp(b, 1'b0, 1'b0, "en_before");
    io.Enable = 1'b0;
    m_screen = 2'd0;
    for (int t = 1; t <= 5; t++) push_exp(b + t, 1'b0, 1'b0, "en_off");
    repeat (5) @(posedge CLOCK_50);
    #1 io.KEY = ~4'b0001;
    b = cyc;
    for (int t = 1; t <= 30; t++) push_exp(b + t, 1'b0, 1'b0, "en_held");
    repeat (12) @(posedge CLOCK_50);
    #1 io.Enable = 1'b1;
    repeat (8) @(posedge CLOCK_50);
    #1 io.KEY = 4'hF;
    repeat (14) @(posedge CLOCK_50);
    press(4'b0001, 1'b0, 10, 1'b0, 2'd1, 3'd0, "en_back_scr1");

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge CLOCK_50);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations left, want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
